window_gen_3x3: RTL and testbench
=================================

WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 640: pixels per image row, legal range 4..4096.
REQ-002 Parameter IMG_H, default 480: rows per frame, legal range 3..4096.
REQ-003 clk  input  1  Single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 pix_in  input  8  Raster-order pixel, unsigned.
REQ-006 pix_valid  input  1  High means pix_in is accepted this cycle; there is no backpressure.
REQ-007 sof  input  1  Start of frame; qualified by pix_valid.
REQ-008 a, b, c  output  8 each  Window top row, left to right: pixels (x-2,y-2), (x-1,y-2), (x,y-2).
REQ-009 d, e, f  output  8 each  Window middle row: (x-2,y-1), (x-1,y-1), (x,y-1); e is the centre.
REQ-010 g, h, i  output  8 each  Window bottom row: (x-2,y), (x-1,y), (x,y); i is the newest pixel.
REQ-011 en  output  1  Active-low window strobe: 0 means a..i hold a complete, valid 3x3 window for exactly this cycle.
REQ-012 frame_done  output  1  One-cycle high pulse after the last pixel of a frame is accepted.

Function
REQ-013 The block SHALL keep a column counter col (0..IMG_W-1) and a row counter row (0..IMG_H-1) that give the (x,y) position of the next accepted pixel.
REQ-014 On an accepted pixel, col SHALL increment. At IMG_W-1, col SHALL wrap to 0 and row SHALL increment. At (IMG_W-1, IMG_H-1), both SHALL wrap to 0.
REQ-015 When pix_valid=1 and sof=1 together, the block SHALL treat the pixel as (0,0), regardless of counter state, and continue counting from there.
REQ-016 The block SHALL ignore sof when pix_valid=0.
REQ-017 The block SHALL hold two line buffers, each IMG_W deep, holding rows y-1 and y-2. Each accepted pixel SHALL be written at address col, and the displaced entry SHALL cascade to the next buffer.
REQ-018 The window SHALL be built from three 3-stage column shift registers fed by pix_in, line buffer 1 and line buffer 2. They SHALL shift only on accepted pixels.
REQ-019 Latency SHALL be one cycle: a..i and en SHALL update on the clock edge after the cycle in which pixel (x,y) is accepted.
REQ-020 en SHALL be driven 0 for one cycle if and only if the accepted pixel had x>=2 and y>=2. Otherwise en SHALL be 1.
REQ-021 Border positions (x<2 or y<2) SHALL never assert en=0. Row-wrap mixing in the shift registers is therefore never exposed.
REQ-022 In cycles with pix_valid=0: counters, buffers and a..i SHALL hold, en SHALL be 1, and frame_done SHALL be 0.
REQ-023 frame_done SHALL pulse 1 on the cycle after (IMG_W-1, IMG_H-1) is accepted, coincident with that pixel's en.
REQ-024 Each full frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) en=0 cycles.
REQ-025 The pixel at (0,0) after an sof SHALL restart the count. Line-buffer contents from the previous frame SHALL never be exposed, because rows 0 and 1 assert no window.

Reset
REQ-026 While rst_n=0: col=0, row=0, a..i=0, en=1, frame_done=0. These SHALL apply immediately, without waiting for clk.
REQ-027 Line-buffer RAM contents SHALL NOT require reset.
REQ-028 Reset asserted mid-frame SHALL abort the frame. The first pixel accepted after release SHALL be treated as (0,0).

Verification
All scenarios use IMG_W=4, IMG_H=4, with pixel value = 16*y + x.
REQ-029 Full frame, pix_valid held 1, sof with the first pixel -> first en=0 comes the cycle after pixel index 10 (x=2,y=2), with a..i = 00,01,02,10,11,12,20,21,22 (hex).
REQ-030 Same frame -> exactly 4 en=0 cycles, with i = 22, 23, 32, 33. frame_done pulses once, coincident with the i=33 window.
REQ-031 Same frame with pix_valid=0 for 3 cycles between pixels 11 and 12 -> en=1 and a..i unchanged during the gap; window contents identical to REQ-030.
REQ-032 sof asserted with pixel index 6 (mid-row 1) -> that pixel is treated as (0,0); no en=0 appears until 10 more pixels are accepted.
REQ-033 rst_n pulsed low for 1 cycle after pixel 12 -> en=1 and a..i=0 asynchronously; the next frame reproduces the REQ-029 first window.
REQ-034 Two back-to-back frames without sof -> counters wrap; the second frame reproduces the REQ-030 windows and frame_done pulses twice in total.

Source files
------------

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: 3x3 sliding-window generator for a raster-order 8-bit pixel stream.
// Two IMG_W-deep line buffers hold rows y-1 and y-2. Three 3-stage column shift
// registers present the window on a..i, one cycle after the newest pixel is accepted.
//
// Ports
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   pix_in      : raster-order pixel, unsigned 8-bit
//   pix_valid   : pixel accepted this cycle (no backpressure)
//   sof         : start of frame, qualified by pix_valid
//   a, b, c     : window top row    (x-2,y-2) (x-1,y-2) (x,y-2)
//   d, e, f     : window middle row (x-2,y-1) (x-1,y-1) (x,y-1)
//   g, h, i     : window bottom row (x-2,y)   (x-1,y)   (x,y)
//   en          : active-low strobe, 0 for one cycle when a..i is a complete window
//   frame_done  : one-cycle pulse after the last pixel of a frame is accepted
module window_gen_3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       sof,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic [7:0] e,
  output logic [7:0] f,
  output logic [7:0] g,
  output logic [7:0] h,
  output logic [7:0] i,
  output logic       en,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];

  logic [CW-1:0] x;
  logic [RW-1:0] y;
  logic [7:0]    lb1_q;
  logic [7:0]    lb2_q;
  logic          at_window;
  logic          at_last;

  // A qualified sof overrides the counters so the current pixel lands at (0,0).
  always_comb begin
    x         = (pix_valid && sof) ? '0 : col;
    y         = (pix_valid && sof) ? '0 : row;
    lb1_q     = lb1[x];
    lb2_q     = lb2[x];
    at_window = (x >= CW'(2)) && (y >= RW'(2));
    at_last   = (x == COL_LAST) && (y == ROW_LAST);
  end

  // Line buffers need no reset: rows 0 and 1 of every frame rewrite them before
  // any window can expose their contents.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[x] <= pix_in;
      lb2[x] <= lb1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      e          <= '0;
      f          <= '0;
      g          <= '0;
      h          <= '0;
      i          <= '0;
      en         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      en         <= 1'b1;
      frame_done <= 1'b0;
      if (pix_valid) begin
        if (x == COL_LAST) begin
          col <= '0;
          row <= (y == ROW_LAST) ? '0 : y + RW'(1);
        end else begin
          col <= x + CW'(1);
          row <= y;
        end
        a <= b;
        b <= c;
        c <= lb2_q;
        d <= e;
        e <= f;
        f <= lb1_q;
        g <= h;
        h <= i;
        i <= pix_in;
        en         <= ~at_window;
        frame_done <= at_last;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       sof;
  logic [7:0] a, b, c, d, e, f, g, h, i;
  logic       en;
  logic       frame_done;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
    .en(en), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        fd;
    logic        chk;
    logic [71:0] win;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          mx, my;
  logic [71:0] last_win;
  logic        last_known;
  logic [7:0]  exp_i [4] = '{8'h22, 8'h23, 8'h32, 8'h33};
  logic [71:0] first_win = 72'h00_01_02_10_11_12_20_21_22;
  logic [71:0] win_out;

  assign win_out = {a, b, c, d, e, f, g, h, i};

  function automatic logic [7:0] pv(input int x, input int y);
    return 8'(16 * y + x);
  endfunction

  function automatic logic [71:0] win_at(input int x, input int y);
    return {pv(x-2, y-2), pv(x-1, y-2), pv(x, y-2),
            pv(x-2, y-1), pv(x-1, y-1), pv(x, y-1),
            pv(x-2, y),   pv(x-1, y),   pv(x, y)};
  endfunction

  // Drives one cycle at the falling edge, pushes the independently modelled
  // expectation, then returns just after the edge that produces that output.
  task automatic step(input logic v, input logic s);
    exp_t ex;
    @(negedge clk);
    sof = s;
    if (v) begin
      if (s) begin mx = 0; my = 0; end
      pix_valid = 1'b1;
      pix_in    = pv(mx, my);
      ex.en     = !(mx >= 2 && my >= 2);
      ex.fd     = (mx == W-1) && (my == H-1);
      if (!ex.en) begin
        ex.win = win_at(mx, my); ex.chk = 1'b1;
        last_win = ex.win; last_known = 1'b1;
      end else begin
        ex.win = '0; ex.chk = 1'b0; last_known = 1'b0;
      end
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end else begin
      pix_valid = 1'b0;
      pix_in    = 8'(($urandom % 256));
      ex.en = 1'b1; ex.fd = 1'b0; ex.win = last_win; ex.chk = last_known;
    end
    sb.push_back(ex);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b1 || frame_done !== 1'b0 || win_out !== 72'h0) begin
      errors++;
      $display("FAIL reset_async en=%b fd=%b win=%h want en=1 fd=0 win=0", en, frame_done, win_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mx = 0; my = 0; last_win = '0; last_known = 1'b1;
    step(1'b0, 1'b0);
    begin
      exp_t ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd || win_out !== ex.win) begin
        errors++;
        $display("FAIL reset_idle en=%b fd=%b win=%h want en=%b fd=%b win=%h", en, frame_done, win_out, ex.en, ex.fd, ex.win);
      end
    end
  endtask

  task automatic test_full_frame();
    exp_t       ex;
    int         n_win = 0, n_fd = 0, first_k = -1;
    logic [7:0] fd_i = 8'h00;
    logic [7:0] i_seen[$];
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0);
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL full_strobe pix %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
      if (ex.chk) begin
        checks++;
        if (win_out !== ex.win) begin
          errors++;
          $display("FAIL full_window pix %0d got %h want %h", k, win_out, ex.win);
        end
      end
      if (en === 1'b0) begin
        if (first_k < 0) begin
          first_k = k;
          checks++;
          if (win_out !== first_win) begin
            errors++;
            $display("FAIL full_first_window got %h want %h", win_out, first_win);
          end
        end
        n_win++;
        i_seen.push_back(i);
      end
      if (frame_done === 1'b1) begin n_fd++; fd_i = i; end
    end
    checks++;
    if (first_k != 10) begin
      errors++; $display("FAIL full_first_index got %0d want 10", first_k);
    end
    checks++;
    if (n_win != 4 || i_seen.size() != 4) begin
      errors++; $display("FAIL full_window_count got %0d want 4", n_win);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (i_seen[k] !== exp_i[k]) begin
          errors++; $display("FAIL full_i_seq[%0d] got %h want %h", k, i_seen[k], exp_i[k]);
        end
      end
    end
    checks++;
    if (n_fd != 1 || fd_i !== 8'h33) begin
      errors++; $display("FAIL full_frame_done count %0d i=%h want 1 i=33", n_fd, fd_i);
    end
  endtask

  task automatic test_gap();
    exp_t       ex;
    int         n_win = 0;
    logic [7:0] i_seen[$];
    for (int k = 0; k < 19; k++) begin
      // pixels 0..11, three idle cycles (one carrying an unqualified sof), pixels 12..15
      step(!(k >= 12 && k <= 14), (k == 0) || (k == 13));
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL gap_strobe step %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
      if (ex.chk) begin
        checks++;
        if (win_out !== ex.win) begin
          errors++;
          $display("FAIL gap_window step %0d got %h want %h", k, win_out, ex.win);
        end
      end
      if (en === 1'b0) begin n_win++; i_seen.push_back(i); end
    end
    checks++;
    if (n_win != 4 || i_seen.size() != 4) begin
      errors++; $display("FAIL gap_window_count got %0d want 4", n_win);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (i_seen[k] !== exp_i[k]) begin
          errors++; $display("FAIL gap_i_seq[%0d] got %h want %h", k, i_seen[k], exp_i[k]);
        end
      end
    end
  endtask

  task automatic test_sof_mid();
    exp_t ex;
    int   n_win = 0, n_fd = 0, first_k = -1;
    for (int k = 0; k < 22; k++) begin
      step(1'b1, (k == 0) || (k == 6));
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL sofmid_strobe pix %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
      if (ex.chk) begin
        checks++;
        if (win_out !== ex.win) begin
          errors++;
          $display("FAIL sofmid_window pix %0d got %h want %h", k, win_out, ex.win);
        end
      end
      if (en === 1'b0) begin
        if (first_k < 0) first_k = k;
        n_win++;
      end
      if (frame_done === 1'b1) n_fd++;
    end
    checks++;
    if (first_k != 16 || n_win != 4 || n_fd != 1) begin
      errors++;
      $display("FAIL sofmid_summary first=%0d wins=%0d fd=%0d want first=16 wins=4 fd=1", first_k, n_win, n_fd);
    end
  endtask

  task automatic test_async_reset();
    exp_t ex;
    int   n_win = 0, first_k = -1;
    for (int k = 0; k < 13; k++) begin
      step(1'b1, k == 0);
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL rst_pre_strobe pix %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b1 || frame_done !== 1'b0 || win_out !== 72'h0) begin
      errors++;
      $display("FAIL rst_mid_async en=%b fd=%b win=%h want en=1 fd=0 win=0", en, frame_done, win_out);
    end
    @(negedge clk) rst_n = 1'b1;
    mx = 0; my = 0; last_win = '0; last_known = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 1'b0);
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL rst_post_strobe pix %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
      if (ex.chk) begin
        checks++;
        if (win_out !== ex.win) begin
          errors++;
          $display("FAIL rst_post_window pix %0d got %h want %h", k, win_out, ex.win);
        end
      end
      if (en === 1'b0) begin
        if (first_k < 0) begin
          first_k = k;
          checks++;
          if (win_out !== first_win) begin
            errors++;
            $display("FAIL rst_first_window got %h want %h", win_out, first_win);
          end
        end
        n_win++;
      end
    end
    checks++;
    if (first_k != 10 || n_win != 4) begin
      errors++;
      $display("FAIL rst_post_summary first=%0d wins=%0d want first=10 wins=4", first_k, n_win);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       ex;
    int         n_win = 0, n_fd = 0;
    logic [7:0] i_seen[$];
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b0);
      ex = sb.pop_front();
      checks++;
      if (en !== ex.en || frame_done !== ex.fd) begin
        errors++;
        $display("FAIL b2b_strobe pix %0d en=%b fd=%b want en=%b fd=%b", k, en, frame_done, ex.en, ex.fd);
      end
      if (ex.chk) begin
        checks++;
        if (win_out !== ex.win) begin
          errors++;
          $display("FAIL b2b_window pix %0d got %h want %h", k, win_out, ex.win);
        end
      end
      if (en === 1'b0) begin n_win++; i_seen.push_back(i); end
      if (frame_done === 1'b1) n_fd++;
    end
    checks++;
    if (n_win != 8 || n_fd != 2 || i_seen.size() != 8) begin
      errors++;
      $display("FAIL b2b_summary wins=%0d fd=%0d want wins=8 fd=2", n_win, n_fd);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (i_seen[k] !== exp_i[k % 4]) begin
          errors++; $display("FAIL b2b_i_seq[%0d] got %h want %h", k, i_seen[k], exp_i[k % 4]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gap();
    test_sof_mid();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
